// File: rtl/rect_plot_scheduler_if.sv
// rtl/rect_plot_scheduler_if.sv - requester and pixel-port bundle for rect_plot_scheduler
interface rect_plot_scheduler_if;
  logic [2:0]  req;
  logic [23:0] rect_x;
  logic [20:0] rect_y;
  logic [14:0] rect_w;
  logic [11:0] rect_h;
  logic [8:0]  rect_colour;
  logic [2:0]  grant;
  logic [2:0]  done;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot;

  modport master (
    output req, rect_x, rect_y, rect_w, rect_h, rect_colour,
    input  grant, done, x, y, colour, plot
  );

  modport slave (
    input  req, rect_x, rect_y, rect_w, rect_h, rect_colour,
    output grant, done, x, y, colour, plot
  );
endinterface

// File: rtl/rect_plot_scheduler.sv
// rtl/rect_plot_scheduler.sv - round-robin arbiter that rasterises one requester's rectangle at a time
module rect_plot_scheduler #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic                 clk,
  input  logic                 resetn,
  rect_plot_scheduler_if.slave bus,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, GRANT, DRAW, DONE} state_t;

  state_t      state_q;
  logic [2:0]  grant_q;
  logic [2:0]  done_q;
  logic [2:0]  hold_q;
  logic [1:0]  last_q;
  logic [7:0]  base_x_q;
  logic [6:0]  base_y_q;
  logic [4:0]  w_q;
  logic [3:0]  h_q;
  logic [2:0]  colour_q;
  logic [4:0]  col_q;
  logic [3:0]  row_q;
  logic [7:0]  x_q;
  logic [6:0]  y_q;
  logic [2:0]  pix_colour_q;
  logic        plot_q;
  logic        busy_q;

  logic [2:0]  elig;
  logic        win_valid;
  logic [1:0]  win_idx;
  logic [1:0]  cand1, cand2, cand3;
  logic [7:0]  sel_x;
  logic [6:0]  sel_y;
  logic [4:0]  sel_w;
  logic [3:0]  sel_h;
  logic [2:0]  sel_colour;
  logic        at_row_end;
  logic        last_pix;
  logic [4:0]  nxt_col_d;
  logic [3:0]  nxt_row_d;
  logic [8:0]  sum_x_d;
  logic [7:0]  sum_y_d;
  logic        on_screen_d;

  function automatic logic [1:0] inc3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] i);
    return 3'b001 << i;
  endfunction

  // A requester that just finished stays masked until it lowers req once.
  assign elig = bus.req & ~hold_q;

  always_comb begin
    cand1     = inc3(last_q);
    cand2     = inc3(cand1);
    cand3     = inc3(cand2);
    win_valid = |elig;
    win_idx   = cand3;
    if (elig[cand1]) begin
      win_idx = cand1;
    end else if (elig[cand2]) begin
      win_idx = cand2;
    end
  end

  always_comb begin
    sel_x      = bus.rect_x[7:0];
    sel_y      = bus.rect_y[6:0];
    sel_w      = bus.rect_w[4:0];
    sel_h      = bus.rect_h[3:0];
    sel_colour = bus.rect_colour[2:0];
    case (win_idx)
      2'd1: begin
        sel_x      = bus.rect_x[15:8];
        sel_y      = bus.rect_y[13:7];
        sel_w      = bus.rect_w[9:5];
        sel_h      = bus.rect_h[7:4];
        sel_colour = bus.rect_colour[5:3];
      end
      2'd2: begin
        sel_x      = bus.rect_x[23:16];
        sel_y      = bus.rect_y[20:14];
        sel_w      = bus.rect_w[14:10];
        sel_h      = bus.rect_h[11:8];
        sel_colour = bus.rect_colour[8:6];
      end
      default: ;
    endcase
  end

  // Next pixel to present: (0,0) when leaving GRANT, raster successor inside DRAW.
  always_comb begin
    at_row_end = (col_q == w_q - 5'd1);
    last_pix   = at_row_end && (row_q == h_q - 4'd1);
    nxt_col_d  = 5'd0;
    nxt_row_d  = 4'd0;
    if (state_q == DRAW) begin
      if (at_row_end) begin
        nxt_row_d = row_q + 4'd1;
      end else begin
        nxt_col_d = col_q + 5'd1;
        nxt_row_d = row_q;
      end
    end
    sum_x_d     = {1'b0, base_x_q} + {4'd0, nxt_col_d};
    sum_y_d     = {1'b0, base_y_q} + {4'd0, nxt_row_d};
    on_screen_d = ({23'd0, sum_x_d} < 32'(SCREEN_W)) && ({24'd0, sum_y_d} < 32'(SCREEN_H));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      grant_q      <= 3'd0;
      done_q       <= 3'd0;
      hold_q       <= 3'd0;
      last_q       <= 2'd2;
      base_x_q     <= 8'd0;
      base_y_q     <= 7'd0;
      w_q          <= 5'd0;
      h_q          <= 4'd0;
      colour_q     <= 3'd0;
      col_q        <= 5'd0;
      row_q        <= 4'd0;
      x_q          <= 8'd0;
      y_q          <= 7'd0;
      pix_colour_q <= 3'd0;
      plot_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      done_q <= 3'd0;
      plot_q <= 1'b0;
      hold_q <= hold_q & bus.req;
      case (state_q)
        IDLE: begin
          if (win_valid) begin
            state_q  <= GRANT;
            busy_q   <= 1'b1;
            grant_q  <= onehot(win_idx);
            last_q   <= win_idx;
            base_x_q <= sel_x;
            base_y_q <= sel_y;
            w_q      <= sel_w;
            h_q      <= sel_h;
            colour_q <= sel_colour;
          end
        end
        GRANT: begin
          if (w_q == 5'd0 || h_q == 4'd0) begin
            state_q <= DONE;
            grant_q <= 3'd0;
            done_q  <= onehot(last_q);
          end else begin
            state_q      <= DRAW;
            col_q        <= nxt_col_d;
            row_q        <= nxt_row_d;
            x_q          <= sum_x_d[7:0];
            y_q          <= sum_y_d[6:0];
            pix_colour_q <= colour_q;
            plot_q       <= on_screen_d;
          end
        end
        DRAW: begin
          if (last_pix) begin
            state_q <= DONE;
            grant_q <= 3'd0;
            done_q  <= onehot(last_q);
          end else begin
            col_q        <= nxt_col_d;
            row_q        <= nxt_row_d;
            x_q          <= sum_x_d[7:0];
            y_q          <= sum_y_d[6:0];
            pix_colour_q <= colour_q;
            plot_q       <= on_screen_d;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          hold_q  <= onehot(last_q);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.grant  = grant_q;
  assign bus.done   = done_q;
  assign bus.x      = x_q;
  assign bus.y      = y_q;
  assign bus.colour = pix_colour_q;
  assign bus.plot   = plot_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_rect_plot_scheduler.sv
// tb/tb_rect_plot_scheduler.sv - scoreboard bench for rect_plot_scheduler
module tb_rect_plot_scheduler;
  localparam int W = 160;
  localparam int H = 120;
  localparam int K_GRANT = 0;
  localparam int K_PIX   = 1;
  localparam int K_DONE  = 2;

  typedef struct {
    int         kind;
    logic [2:0] v;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic       p;
  } ev_t;

  logic clk = 1'b0;
  logic resetn;
  logic busy;

  rect_plot_scheduler_if bus();

  rect_plot_scheduler #(.SCREEN_W(W), .SCREEN_H(H)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  int  n_checks = 0;
  int  n_fail   = 0;
  ev_t exp_q[$];
  int  m_last;
  int  rx[3], ry[3], rw[3], rh[3], rc[3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_rects();
    bus.rect_x      = {8'(rx[2]), 8'(rx[1]), 8'(rx[0])};
    bus.rect_y      = {7'(ry[2]), 7'(ry[1]), 7'(ry[0])};
    bus.rect_w      = {5'(rw[2]), 5'(rw[1]), 5'(rw[0])};
    bus.rect_h      = {4'(rh[2]), 4'(rh[1]), 4'(rh[0])};
    bus.rect_colour = {3'(rc[2]), 3'(rc[1]), 3'(rc[0])};
  endtask

  task automatic set_rect(input int i, input int x, input int y, input int w, input int h, input int c);
    rx[i] = x; ry[i] = y; rw[i] = w; rh[i] = h; rc[i] = c;
    drive_rects();
  endtask

  task automatic random_rect(input int i);
    rx[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(140, 180)) : int'($urandom_range(0, 255));
    ry[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(110, 127)) : int'($urandom_range(0, 127));
    rw[i] = int'($urandom_range(0, 16));
    rh[i] = int'($urandom_range(0, 8));
    rc[i] = int'($urandom_range(0, 7));
  endtask

  // Round-robin reference: first requested index after the previous winner, mod 3.
  function automatic int pick(input logic [2:0] mask);
    int i;
    for (int k = 1; k <= 3; k++) begin
      i = (m_last + k) % 3;
      if (mask[i]) return i;
    end
    return -1;
  endfunction

  task automatic push_rect(input int i);
    ev_t e;
    int  px, py;
    e.kind = K_GRANT; e.v = 3'(1 << i); e.x = '0; e.y = '0; e.c = '0; e.p = 1'b0;
    exp_q.push_back(e);
    for (int r = 0; r < rh[i]; r++) begin
      for (int cc = 0; cc < rw[i]; cc++) begin
        px     = rx[i] + cc;
        py     = ry[i] + r;
        e.kind = K_PIX;
        e.x    = 8'(px);
        e.y    = 7'(py);
        e.c    = 3'(rc[i]);
        e.p    = (px < W) && (py < H);
        exp_q.push_back(e);
      end
    end
    e.kind = K_DONE; e.v = 3'(1 << i); e.p = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic pop(output ev_t e, output bit ok);
    e.kind = -1; e.v = '0; e.x = '0; e.y = '0; e.c = '0; e.p = 1'b0;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      ok = 1'b0;
      $display("FAIL unexpected_event: got grant=%b done=%b plot=%b expected no activity at %0t",
               bus.grant, bus.done, bus.plot, $time);
    end else begin
      e  = exp_q.pop_front();
      ok = 1'b1;
    end
  endtask

  task automatic wait_done(output int n, output logic [2:0] d);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.done === 3'b000 && n < 400);
    d = bus.done;
    if (d === 3'b000) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got no done after %0d cycles expected a done pulse", n);
    end
  endtask

  task automatic run_txn(input logic [2:0] mask, input bit scramble);
    int         w, n, exp_n;
    logic [2:0] d;
    w     = pick(mask);
    exp_n = (rw[w] == 0 || rh[w] == 0) ? 1 : rw[w] * rh[w] + 1;
    push_rect(w);
    m_last  = w;
    bus.req = mask;
    @(negedge clk);
    chk("grant_latency", bus.grant, 32'(1 << w));
    bus.req = 3'b000;
    if (scramble) begin
      for (int i = 0; i < 3; i++) random_rect(i);
      drive_rects();
    end
    wait_done(n, d);
    chk("done_latency", n, exp_n);
    repeat (2) @(negedge clk);
  endtask

  logic [2:0] prev_grant = 3'b000;
  bit         after_done = 1'b0;

  always @(negedge clk) begin
    ev_t e;
    bit  ok;
    if (!resetn) begin
      prev_grant = 3'b000;
      after_done = 1'b0;
    end else begin
      if (bus.done !== 3'b000) begin
        pop(e, ok);
        if (ok) begin
          chk("done_kind", e.kind, K_DONE);
          chk("done_value", bus.done, e.v);
          chk("done_grant_low", bus.grant, 0);
          chk("done_plot_low", bus.plot, 0);
        end
        after_done = 1'b1;
      end else if (bus.grant !== 3'b000) begin
        pop(e, ok);
        if (ok) begin
          if (prev_grant == 3'b000) begin
            chk("grant_kind", e.kind, K_GRANT);
            chk("grant_value", bus.grant, e.v);
            chk("grant_plot_low", bus.plot, 0);
            chk("grant_busy", busy, 1);
          end else begin
            chk("pix_kind", e.kind, K_PIX);
            chk("pix_grant_stable", bus.grant, prev_grant);
            chk("pix_plot", bus.plot, e.p);
            if (e.p) begin
              chk("pix_x", bus.x, e.x);
              chk("pix_y", bus.y, e.y);
              chk("pix_colour", bus.colour, e.c);
            end
          end
        end
        after_done = 1'b0;
      end else begin
        if (after_done) begin
          chk("busy_after_done", busy, 0);
          chk("idle_plot_low", bus.plot, 0);
        end
        after_done = 1'b0;
      end
      prev_grant = bus.grant;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test expected completion within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         n;
    logic [2:0] d;
    logic [2:0] live;
    int         w;

    resetn  = 1'b0;
    bus.req = 3'b000;
    set_rect(0, 1, 1, 2, 1, 1);
    set_rect(1, 5, 5, 1, 2, 2);
    set_rect(2, 20, 30, 3, 1, 3);
    m_last = 2;
    repeat (3) @(negedge clk);

    chk("rst_grant", bus.grant, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_plot", bus.plot, 0);
    chk("rst_busy", busy, 0);
    chk("rst_x", bus.x, 0);
    chk("rst_y", bus.y, 0);
    chk("rst_colour", bus.colour, 0);

    // All three requesting from reset, each drops one cycle after its done.
    for (int round = 0; round < 2; round++) begin
      live = 3'b111;
      for (int k = 0; k < 3; k++) begin
        w = pick(live);
        push_rect(w);
        m_last  = w;
        live[w] = 1'b0;
      end
      bus.req = 3'b111;
      resetn  = 1'b1;
      for (int k = 0; k < 3; k++) begin
        wait_done(n, d);
        @(negedge clk);
        bus.req = bus.req & ~d;
      end
      bus.req = 3'b000;
      repeat (2) @(negedge clk);
    end

    set_rect(0, 10, 20, 2, 2, 5);
    run_txn(3'b001, 1'b0);

    set_rect(0, 155, 0, 8, 1, 3);
    run_txn(3'b001, 1'b0);

    set_rect(1, 40, 40, 0, 5, 2);
    run_txn(3'b010, 1'b0);

    // Held request must not be re-granted until it drops for a cycle.
    set_rect(0, 0, 0, 1, 1, 7);
    w = pick(3'b001);
    push_rect(w);
    m_last  = w;
    bus.req = 3'b001;
    wait_done(n, d);
    repeat (6) @(negedge clk);
    chk("held_no_regrant", bus.grant, 0);
    chk("held_not_busy", busy, 0);
    bus.req = 3'b000;
    @(negedge clk);
    w = pick(3'b001);
    push_rect(w);
    m_last  = w;
    bus.req = 3'b001;
    @(negedge clk);
    chk("regrant_after_drop", bus.grant, 1);
    wait_done(n, d);
    bus.req = 3'b000;
    repeat (2) @(negedge clk);

    // Asynchronous reset in the third DRAW cycle.
    set_rect(1, 3, 3, 4, 2, 6);
    push_rect(1);
    m_last  = 1;
    bus.req = 3'b010;
    @(negedge clk);
    chk("abort_grant_latency", bus.grant, 3'b010);
    bus.req = 3'b000;
    repeat (3) @(negedge clk);
    chk("abort_plot_before", bus.plot, 1);
    #2;
    resetn = 1'b0;
    #1;
    chk("async_plot", bus.plot, 0);
    chk("async_grant", bus.grant, 0);
    chk("async_busy", busy, 0);
    exp_q.delete();
    m_last = 2;
    @(negedge clk);
    chk("abort_no_done", bus.done, 0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    run_txn(3'b010, 1'b0);

    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 3; i++) random_rect(i);
      drive_rects();
      run_txn(3'($urandom_range(1, 7)), 1'b1);
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
